// File: rtl/saradc_seq_pkg.sv
// Shared definitions for the SAR ADC sequencer: FSM encoding, default
// parameter values and the accumulator width helper.
package saradc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NBITS    = 8;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_TMO_W    = 12;

  // Sum of 2^avg_log2 samples of nbits each never exceeds this width.
  function automatic int acc_w(input int nbits, input int avg_log2);
    return nbits + avg_log2;
  endfunction

endpackage

// File: rtl/saradc_seq_if.sv
// Valid/ready stream carrying averaged samples out of the sequencer.
// master drives data/valid, slave drives ready.
interface saradc_seq_if
  import saradc_seq_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) ();

  logic [NBITS-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/saradc_seq_outreg.sv
// Single-entry output register for completed averages. A new average that
// arrives while the previous one is still waiting (valid, not ready) is
// dropped and recorded in the sticky overrun flag.
module saradc_seq_outreg
  import saradc_seq_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NBITS-1:0] data,
  input  logic             clr_ovr,
  saradc_seq_if.master     out_if,
  output logic             overrun
);

  logic can_load;
  logic xfer;

  assign xfer     = out_if.out_valid & out_if.out_ready;
  assign can_load = ~out_if.out_valid | out_if.out_ready;

  // Load, hand off or hold the pending average; track dropped averages
  always_ff @(posedge clk) begin
    if (rst) begin
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (load && can_load) begin
        out_if.out_data  <= data;
        out_if.out_valid <= 1'b1;
      end else if (xfer) begin
        out_if.out_valid <= 1'b0;
      end
      if (load && !can_load) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/saradc_seq.sv
// SAR ADC sequencer: issues periodic GO requests, captures RESULT on each
// VALID rising edge, averages 2^AVG_LOG2 conversions and hands the average
// to a valid/ready output register.
// Optional conversion watchdog with TIMEOUT pulse: SARADC_SEQ_TIMEOUT_EN.
module saradc_seq
  import saradc_seq_pkg::*;
#(
  parameter int NBITS    = DEF_NBITS,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int TMO_W    = DEF_TMO_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                go,
  input  logic                valid,
  input  logic [NBITS-1:0]    result,
  saradc_seq_if.master        out_if,
  output logic                overrun,
  output logic                busy
`ifdef SARADC_SEQ_TIMEOUT_EN
  ,
  output logic                timeout
`endif
);

  localparam int ACC_W  = acc_w(NBITS, AVG_LOG2);
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  state_t              state;
  state_t              state_nxt;
  logic                vld_q;
  logic                vrise;
  logic                start_ok;
  logic                enter_conv;
  logic                last_smp;
  logic                complete;
  logic                clr_ovr;
  logic [PERIOD_W-1:0] pcnt;
  logic [SCNT_W-1:0]   scnt;
  logic [ACC_W-1:0]    acc;
  logic [NBITS-1:0]    avg;

`ifdef SARADC_SEQ_TIMEOUT_EN
  // Abort on the edge where the watchdog would step onto all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  logic [TMO_W-1:0] tmo;
  logic             tmo_hit;
  assign tmo_hit = (state == CONV) && (tmo == TMO_LAST);
`endif

  // VALID may already be high when CONV is entered; only a fresh rising
  // edge counts as a conversion result.
  assign vrise    = valid & ~vld_q;
  assign start_ok = en & ((period == '0) | (pcnt >= period - PERIOD_W'(1)));

  if (AVG_LOG2 == 0) begin : g_noavg
    assign last_smp = 1'b1;
  end else begin : g_avg
    assign last_smp = &scnt;
  end

  assign complete   = (state == DONE) & last_smp;
  assign avg        = acc[ACC_W-1:AVG_LOG2];
  assign enter_conv = (state != CONV) & (state_nxt == CONV);
  assign clr_ovr    = (state == IDLE) & ~en;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = CONV;
      end
      CONV: begin
        if (vrise) state_nxt = DONE;
`ifdef SARADC_SEQ_TIMEOUT_EN
        else if (tmo_hit) state_nxt = IDLE;
`endif
      end
      DONE: begin
        state_nxt = start_ok ? CONV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, VALID edge detector and registered GO/BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vld_q <= 1'b0;
      go    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      vld_q <= valid;
      go    <= (state_nxt == CONV);
      busy  <= (state_nxt != IDLE);
    end
  end

  // Period counter measures from each GO start so restarts keep the cadence
  always_ff @(posedge clk) begin
    if (rst || enter_conv) begin
      pcnt <= '0;
    end else if (pcnt != '1) begin
      pcnt <= pcnt + PERIOD_W'(1);
    end
  end

  // Accumulate samples; clear on completion, on disable or on abort
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      scnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!en) begin
            acc  <= '0;
            scnt <= '0;
          end
        end
        CONV: begin
          if (vrise) begin
            acc <= acc + ACC_W'(result);
          end
`ifdef SARADC_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            acc  <= '0;
            scnt <= '0;
          end
`endif
        end
        DONE: begin
          if (last_smp || !en) begin
            acc  <= '0;
            scnt <= '0;
          end else begin
            scnt <= scnt + SCNT_W'(1);
          end
        end
        default: begin
          acc  <= '0;
          scnt <= '0;
        end
      endcase
    end
  end

`ifdef SARADC_SEQ_TIMEOUT_EN
  // Conversion watchdog, running only while waiting in CONV
  always_ff @(posedge clk) begin
    if (rst || state != CONV) begin
      tmo <= '0;
    end else begin
      tmo <= tmo + TMO_W'(1);
    end
  end

  // One-cycle TIMEOUT pulse when a conversion is abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit & ~vrise;
    end
  end
`endif

  saradc_seq_outreg #(
    .NBITS(NBITS)
  ) u_outreg (
    .clk    (clk),
    .rst    (rst),
    .load   (complete),
    .data   (avg),
    .clr_ovr(clr_ovr),
    .out_if (out_if),
    .overrun(overrun)
  );

endmodule

// File: tb/tb_saradc_seq.sv
// Self-checking bench for saradc_seq: an ADC responder answers GO after a
// programmable latency, a monitor timestamps events, and each test compares
// against averages and cadences computed from the sample stream.
`timescale 1ns/1ps
module tb_saradc_seq;
  import saradc_seq_pkg::*;

  localparam int NB   = 8;
  localparam int AL   = 2;
  localparam int PW   = 16;
  localparam int TW   = 4;
  localparam int NAVG = 1 << AL;
`ifdef SARADC_SEQ_TIMEOUT_EN
  localparam int SLOW_LAT = 13;
  localparam int MAX_LAT  = 12;
`else
  localparam int SLOW_LAT = 30;
  localparam int MAX_LAT  = 24;
`endif
  localparam int Q_GO = 0, Q_GOF = 1, Q_VR = 2, Q_OV = 3, Q_XF = 4;

  logic          clk = 1'b0;
  logic          rst, en, go, valid, overrun, busy;
  logic [PW-1:0] period;
  logic [NB-1:0] result;
`ifdef SARADC_SEQ_TIMEOUT_EN
  logic          timeout;
`endif

  saradc_seq_if #(.NBITS(NB)) out_if ();

  saradc_seq #(.NBITS(NB), .AVG_LOG2(AL), .PERIOD_W(PW), .TMO_W(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .go     (go),
    .valid  (valid),
    .result (result),
    .out_if (out_if),
    .overrun(overrun),
    .busy   (busy)
`ifdef SARADC_SEQ_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ADC responder: pulses VALID for one cycle in the adc_lat-th cycle of GO
  int            adc_lat = 10;
  bit            adc_mute = 1'b0;
  int            go_cnt = 0;
  logic [NB-1:0] feed_q[$];
  logic [NB-1:0] smp_q[$];

  initial begin
    valid = 1'b0;
    result = '0;
    forever begin
      @(negedge clk);
      valid = 1'b0;
      if (go === 1'b1) begin
        go_cnt++;
        if (!adc_mute && go_cnt == adc_lat) begin
          valid = 1'b1;
          result = (feed_q.size() > 0) ? feed_q.pop_front() : NB'($urandom);
          smp_q.push_back(result);
        end
      end else begin
        go_cnt = 0;
      end
    end
  end

  // Monitor: timestamps (edge index) of observed events, sampled 1ns after each edge
  int            cyc = 0;
  int            go_rise_q[$], go_fall_q[$], vr_q[$], ov_rise_q[$], to_q[$];
  logic [NB-1:0] xfer_q[$];
  logic          go_d = 1'b0, valid_d = 1'b0, ov_d = 1'b0;
  logic [NB-1:0] od_d = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (go && !go_d) go_rise_q.push_back(cyc);
      if (!go && go_d) go_fall_q.push_back(cyc);
      if (valid && !valid_d) vr_q.push_back(cyc);
      if (out_if.out_valid && !ov_d) ov_rise_q.push_back(cyc);
      if (ov_d && out_if.out_ready) xfer_q.push_back(od_d);
`ifdef SARADC_SEQ_TIMEOUT_EN
      if (timeout) to_q.push_back(cyc);
`endif
      go_d = go;
      valid_d = valid;
      ov_d = out_if.out_valid;
      od_d = out_if.out_data;
    end
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int qsize(input int which);
    case (which)
      Q_GO:    return go_rise_q.size();
      Q_GOF:   return go_fall_q.size();
      Q_VR:    return vr_q.size();
      Q_OV:    return ov_rise_q.size();
      Q_XF:    return xfer_q.size();
      default: return 0;
    endcase
  endfunction

  // Expected average number k of the recorded sample stream
  function automatic logic [NB-1:0] avg_of(input int k);
    int s = 0;
    for (int i = 0; i < NAVG; i++) s += int'(smp_q[k*NAVG+i]);
    return NB'(s >> AL);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ev(input int which, input int n, input int budget, output bit ok);
    int t = 0;
    while (qsize(which) < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (qsize(which) >= n);
  endtask

  task automatic clr_q();
    go_rise_q.delete(); go_fall_q.delete(); vr_q.delete();
    ov_rise_q.delete(); xfer_q.delete(); to_q.delete();
    smp_q.delete(); feed_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; out_if.out_ready = 1'b1; adc_mute = 1'b0;
    tick(3);
    rst = 1'b0;
    clr_q();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; period = 16'd20; out_if.out_ready = 1'b1;
    tick(4);
    n_cmp++;
    if ({go, out_if.out_valid, out_if.out_data, overrun, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got go/ov/data/ovr/busy=%b/%b/%h/%b/%b want all 0",
               go, out_if.out_valid, out_if.out_data, overrun, busy);
    end
`ifdef SARADC_SEQ_TIMEOUT_EN
    n_cmp++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_cadence();
    bit ok;
    do_reset();
    period = 16'd20; adc_lat = 10;
    repeat (3 * NAVG) feed_q.push_back(8'hA5);
    en = 1'b1;
    wait_ev(Q_XF, 3, 800, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL cadence_wait: got %0d transfers want 3", xfer_q.size()); end
    if (ok) begin
      for (int i = 1; i < go_rise_q.size(); i++) begin
        n_cmp++;
        if (go_rise_q[i] - go_rise_q[i-1] !== 20) begin
          n_fail++;
          $display("FAIL cadence_go_interval[%0d]: got %0d want 20", i, go_rise_q[i] - go_rise_q[i-1]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        // VALID sampled at edge vr (CONV->DONE); DONE loads the output at the next edge
        n_cmp++;
        if (ov_rise_q[k] !== vr_q[k*NAVG+NAVG-1] + 1) begin
          n_fail++;
          $display("FAIL cadence_latency[%0d]: got edge %0d want %0d", k, ov_rise_q[k], vr_q[k*NAVG+NAVG-1] + 1);
        end
        n_cmp++;
        if (xfer_q[k] !== 8'hA5) begin
          n_fail++;
          $display("FAIL cadence_data[%0d]: got %h want a5", k, xfer_q[k]);
        end
      end
    end
  endtask

  task automatic test_average();
    bit ok;
    logic [NB-1:0] vals [8] = '{8'd10, 8'd11, 8'd12, 8'd14, 8'd255, 8'd255, 8'd255, 8'd255};
    do_reset();
    period = 16'd8; adc_lat = 5;
    foreach (vals[i]) feed_q.push_back(vals[i]);
    en = 1'b1;
    wait_ev(Q_XF, 2, 400, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL avg_wait: got %0d transfers want 2", xfer_q.size()); end
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (xfer_q[k] !== avg_of(k)) begin
          n_fail++;
          $display("FAIL avg_data[%0d]: got %0d want %0d", k, xfer_q[k], avg_of(k));
        end
        n_cmp++;
        if (ov_rise_q[k] !== vr_q[k*NAVG+NAVG-1] + 1) begin
          n_fail++;
          $display("FAIL avg_single_valid[%0d]: got edge %0d want %0d", k, ov_rise_q[k], vr_q[k*NAVG+NAVG-1] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [NB-1:0] a;
    int t;
    do_reset();
    out_if.out_ready = 1'b0; period = 16'd8; adc_lat = 5;
    en = 1'b1;
    wait_ev(Q_OV, 1, 300, ok);
    a = avg_of(0);
    n_cmp++;
    if (!ok || out_if.out_data !== a || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got data=%h ovr=%b want data=%h ovr=0", out_if.out_data, overrun, a);
    end
    wait_ev(Q_VR, 2 * NAVG, 300, ok);
    tick(2);
    n_cmp++;
    if (!ok || {out_if.out_valid, overrun} !== 2'b11 || out_if.out_data !== a) begin
      n_fail++;
      $display("FAIL bp_overrun: got valid=%b ovr=%b data=%h want valid=1 ovr=1 data=%h",
               out_if.out_valid, overrun, out_if.out_data, a);
    end
    en = 1'b0;
    t = 0;
    while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    tick(2);
    n_cmp++;
    if (overrun !== 1'b0 || out_if.out_valid !== 1'b1 || out_if.out_data !== a) begin
      n_fail++;
      $display("FAIL bp_ovr_clear: got ovr=%b valid=%b data=%h want ovr=0 valid=1 data=%h",
               overrun, out_if.out_valid, out_if.out_data, a);
    end
    out_if.out_ready = 1'b1;
    tick(2);
    n_cmp++;
    if (xfer_q.size() !== 1 || out_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got transfers=%0d valid=%b want 1/0", xfer_q.size(), out_if.out_valid);
    end else begin
      n_cmp++;
      if (xfer_q[0] !== a) begin n_fail++; $display("FAIL bp_drain_data: got %h want %h", xfer_q[0], a); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    // Two passes: PERIOD=0 with a short conversion, PERIOD=5 with a slow one
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      lat = (pass == 0) ? int'($urandom_range(1, 8)) : SLOW_LAT;
      period = (pass == 0) ? 16'd0 : 16'd5;
      adc_lat = lat;
      en = 1'b1;
      wait_ev(Q_GO, 6, 400, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL b2b_wait[%0d]: got %0d GO starts want 6", pass, go_rise_q.size()); end
      if (ok) begin
        for (int i = 1; i < 6; i++) begin
          n_cmp++;
          if (go_rise_q[i] - go_rise_q[i-1] !== lat + 1) begin
            n_fail++;
            $display("FAIL b2b_interval[%0d][%0d]: got %0d want %0d", pass, i, go_rise_q[i] - go_rise_q[i-1], lat + 1);
          end
          n_cmp++;
          if (go_fall_q[i-1] - go_rise_q[i-1] !== lat) begin
            n_fail++;
            $display("FAIL b2b_go_width[%0d][%0d]: got %0d want %0d", pass, i, go_fall_q[i-1] - go_rise_q[i-1], lat);
          end
        end
      end
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    int lowcnt, t;
    do_reset();
    period = 16'd20; adc_lat = 10;
    en = 1'b1;
    wait_ev(Q_GO, 3, 200, ok);
    tick(4);
    en = 1'b0;
    lowcnt = 0; t = 0;
    while (vr_q.size() < 3 && t < 60) begin
      if (go !== 1'b1) lowcnt++;
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!ok || vr_q.size() != 3 || lowcnt != 0) begin
      n_fail++;
      $display("FAIL endrop_go_held: got vrises=%0d go_low_cycles=%0d want 3/0", vr_q.size(), lowcnt);
    end
    tick(3);
    n_cmp++;
    if ({busy, go} !== 2'b00) begin n_fail++; $display("FAIL endrop_idle: got busy=%b go=%b want 0/0", busy, go); end
    tick(40);
    n_cmp++;
    if (go_rise_q.size() != 3 || ov_rise_q.size() != 0) begin
      n_fail++;
      $display("FAIL endrop_quiet: got starts=%0d outputs=%0d want 3/0", go_rise_q.size(), ov_rise_q.size());
    end
    clr_q();
    en = 1'b1;
    wait_ev(Q_XF, 1, 400, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL endrop_resume_wait: got %0d transfers want 1", xfer_q.size());
    end else begin
      n_cmp++;
      if (xfer_q[0] !== avg_of(0) || ov_rise_q[0] !== vr_q[NAVG-1] + 1) begin
        n_fail++;
        $display("FAIL endrop_fresh_avg: got %h at edge %0d want %h at edge %0d",
                 xfer_q[0], ov_rise_q[0], avg_of(0), vr_q[NAVG-1] + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    do_reset();
    out_if.out_ready = 1'b0; period = 16'd8; adc_lat = 5;
    en = 1'b1;
    wait_ev(Q_VR, 2 * NAVG, 300, ok);
    tick(2);
    t = 0;
    while (go !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    tick(2);
    n_cmp++;
    if (!ok || {go, out_if.out_valid, overrun} !== 3'b111) begin
      n_fail++;
      $display("FAIL rstmid_pre: got go/valid/ovr=%b%b%b want 111", go, out_if.out_valid, overrun);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({go, out_if.out_valid, out_if.out_data, overrun, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got go/ov/data/ovr/busy=%b/%b/%h/%b/%b want all 0",
               go, out_if.out_valid, out_if.out_data, overrun, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      period = PW'($urandom_range(0, 30));
      adc_lat = $urandom_range(1, MAX_LAT);
      repeat (4 * NAVG) feed_q.push_back(NB'($urandom));
      en = 1'b1;
      wait_ev(Q_XF, 4, 1500, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rand_wait[%0d]: got %0d transfers want 4", it, xfer_q.size()); end
      if (ok) begin
        for (int k = 0; k < 4; k++) begin
          n_cmp++;
          if (xfer_q[k] !== avg_of(k)) begin
            n_fail++;
            $display("FAIL rand_data[%0d][%0d]: got %h want %h (period=%0d lat=%0d)",
                     it, k, xfer_q[k], avg_of(k), period, adc_lat);
          end
        end
      end
    end
  endtask

`ifdef SARADC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c0;
    do_reset();
    adc_mute = 1'b1; period = 16'd40;
    en = 1'b1;
    wait_ev(Q_GO, 1, 100, ok);
    c0 = ok ? go_rise_q[0] : 0;
    wait_ev(Q_GOF, 1, 50, ok);
    n_cmp++;
    if (!ok || go_fall_q[0] - c0 != 15) begin
      n_fail++;
      $display("FAIL tmo_go_drop: got %0d cycles want 15", ok ? go_fall_q[0] - c0 : -1);
    end
    wait_ev(Q_GO, 2, 100, ok);
    n_cmp++;
    if (to_q.size() != 1) begin
      n_fail++;
      $display("FAIL tmo_pulse_count: got %0d want 1", to_q.size());
    end else begin
      n_cmp++;
      if (to_q[0] - c0 != 15) begin n_fail++; $display("FAIL tmo_pulse_time: got %0d want 15", to_q[0] - c0); end
    end
    n_cmp++;
    if (!ok || go_rise_q[1] - c0 != 40) begin
      n_fail++;
      $display("FAIL tmo_next_go: got %0d want 40", ok ? go_rise_q[1] - c0 : -1);
    end
    en = 1'b0;
    adc_mute = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; period = '0; out_if.out_ready = 1'b1;
    test_reset();
    test_cadence();
    test_average();
    test_backpressure();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
`ifdef SARADC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/saradc_seq.md
Name: saradc_seq

Overview:
- Digital sequencer directly downstream of the SARADC macro.
- Issues periodic GO pulses and captures RESULT on each VALID rising edge.
- Averages 2^AVG_LOG2 conversions and presents the average on a valid/ready output towards the register/stream interface.
- Runs on the same clock domain as the SAR logic.

Parameters:
- NBITS, 8: width of the ADC RESULT and of OUT_DATA.
- AVG_LOG2, 2: log2 of the number of conversions averaged per output. 0 means no averaging.
- PERIOD_W, 16: width of the PERIOD input and of the period counter.
- TMO_W, 12: width of the conversion watchdog counter. Used only with the optional feature.

Ports:
- CLK  in  1  clock, same clock as the SAR digital logic.
- RST  in  1  reset, synchronous active-high.
- EN  in  1  sequencing enable.
- PERIOD  in  PERIOD_W  cycles between successive GO assertions. 0 means back-to-back.
- GO  out  1  conversion request to SAR logic.
- VALID  in  1  conversion done, from SAR logic.
- RESULT  in  NBITS  conversion result, from SAR logic.
- OUT_DATA  out  NBITS  averaged sample.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream accepts OUT_DATA.
- OVERRUN  out  1  sticky flag: an average was dropped.
- BUSY  out  1  high when FSM is not in IDLE.

Behaviour:
- Reset state: GO=0, OUT_VALID=0, OUT_DATA=0, OVERRUN=0, BUSY=0, accumulator=0, sample count=0, period counter=0, FSM=IDLE, vld_q=0.
- All outputs are registered.
- vld_q is VALID delayed one cycle. vrise = VALID & ~vld_q.
- Period counter pcnt:
  - Cleared to 0 on every IDLE->CONV transition.
  - Otherwise increments each cycle and saturates at all-ones.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - Go to CONV when EN=1 and (pcnt >= PERIOD-1, or PERIOD==0).
  - GO<=1 on the same edge, so GO is high from the first CONV cycle.
- CONV:
  - GO held 1.
  - On vrise: capture RESULT into the accumulator (acc <= acc + RESULT), GO<=0, go to DONE.
  - VALID high already on CONV entry (no edge) is ignored until it falls and rises again.
- DONE (one cycle):
  - Increment sample count scnt (width AVG_LOG2, wraps).
  - If scnt wraps to 0, the average completes.
  - Then go to IDLE, or straight back to CONV if the IDLE condition already holds.
  - A conversion longer than PERIOD therefore restarts immediately; no starts are queued.
- Accumulator:
  - Width NBITS+AVG_LOG2, cannot overflow.
  - On completion, the average is acc[NBITS+AVG_LOG2-1:AVG_LOG2] (truncating), and acc is cleared in the same cycle.
- Output register:
  - On completion with OUT_VALID=0, or with OUT_VALID=1 and OUT_READY=1 that cycle: load OUT_DATA, OUT_VALID<=1.
  - On completion with OUT_VALID=1 and OUT_READY=0: drop the new average, OVERRUN<=1, OUT_DATA unchanged.
  - Handshake transfer when OUT_VALID & OUT_READY. OUT_VALID then clears unless reloaded the same cycle.
  - OUT_DATA is stable while OUT_VALID & ~OUT_READY.
- EN deassert:
  - The in-flight conversion completes normally: GO stays high until vrise.
  - DONE then returns to IDLE.
  - The partial accumulator and scnt are cleared.
  - A completed average is still delivered.
  - OVERRUN is cleared while EN=0 and in IDLE.
- RST mid-conversion: immediate return to the reset state. GO drops on the next edge.
- Latency: vrise on the last sample to OUT_VALID=1 is 2 cycles (CONV->DONE, DONE loads the output).
- PERIOD change takes effect at the next IDLE evaluation.

Optional Feature:
- Macro: SARADC_SEQ_TIMEOUT_EN.
- When defined:
  - CONV runs a watchdog counter of TMO_W bits, cleared on CONV entry.
  - If it reaches all-ones before vrise: GO<=0, abort the conversion, clear acc/scnt, go to IDLE.
  - Pulse the extra output port TIMEOUT (out, 1) for one cycle.
- When not defined:
  - No counter and no TIMEOUT port.
  - CONV waits indefinitely.

Decomposition:
- Package saradc_seq_pkg holds:
  - The FSM state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2).
  - The default parameter constants.
  - The accumulator-width function NBITS+AVG_LOG2.
- One natural sub-module, saradc_seq_outreg: the single-entry valid/ready output register with overrun detection.
- FSM, counters and accumulator stay in the top module.

Test Plan:
- Conversion cadence: RST, EN=1, PERIOD=20, AVG_LOG2=0, model returns VALID 10 cycles after GO with RESULT=8'hA5 -> GO asserts every 20 cycles; OUT_DATA=8'hA5, OUT_VALID=1 two cycles after each vrise.
- Averaging: AVG_LOG2=2, RESULTs 10,11,12,14 -> exactly one OUT_VALID, OUT_DATA=11 (47>>2). Next 4 samples all 255 -> OUT_DATA=255, no overflow.
- Backpressure and overrun: OUT_READY=0, two averages complete -> OUT_DATA keeps the first value, OVERRUN=1 after the second. EN=0 in IDLE -> OVERRUN=0.
- Back-to-back and slow ADC: PERIOD=0 -> new GO in the cycle after DONE. PERIOD=5 with 30-cycle conversions -> GO restarts right after each DONE, none lost or queued.
- EN drop and reset: EN=0 mid-CONV -> GO held until vrise, then IDLE, acc cleared, BUSY=0. RST mid-CONV -> GO=0 and all outputs at reset values on the next edge.
- SARADC_SEQ_TIMEOUT_EN, TMO_W=4, model never raises VALID -> GO drops and a single TIMEOUT pulse 15 cycles after CONV entry; the next GO follows PERIOD.
